// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit:
// FSM states, instruction classes, opcode patterns and datapath select encodings.
package mcycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR,
    C_ADDI, C_SUBI, C_ANDI, C_ORRI, C_CBZ, C_CBNZ, C_B
  } class_e;

  // Patterns are the significant leading bits only; trailing bits are don't-care.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_ORR   = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  localparam logic [1:0] SEU_I  = 2'b00;
  localparam logic [1:0] SEU_D  = 2'b01;
  localparam logic [1:0] SEU_B  = 2'b10;
  localparam logic [1:0] SEU_CB = 2'b11;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] seu;
    logic [2:0] alu_op;
  } sel_t;

  function automatic logic is_branch(class_e c);
    return (c == C_CBZ) || (c == C_CBNZ) || (c == C_B);
  endfunction

  function automatic logic is_mem(class_e c);
    return (c == C_LDUR) || (c == C_STUR);
  endfunction

  // Datapath selects for a class; anything not meaningful for the class stays 0.
  function automatic sel_t class_sels(class_e c);
    sel_t s;
    s = '0;
    case (c)
      C_SUB:  s.alu_op = ALU_SUB;
      C_AND:  s.alu_op = ALU_AND;
      C_ORR:  s.alu_op = ALU_ORR;
      C_ADDI: s.alu_src = 1'b1;
      C_SUBI: begin s.alu_src = 1'b1; s.alu_op = ALU_SUB; end
      C_ANDI: begin s.alu_src = 1'b1; s.alu_op = ALU_AND; end
      C_ORRI: begin s.alu_src = 1'b1; s.alu_op = ALU_ORR; end
      C_LDUR: begin s.alu_src = 1'b1; s.seu = SEU_D; s.mem_to_reg = 1'b1; end
      C_STUR: begin s.reg2loc = 1'b1; s.alu_src = 1'b1; s.seu = SEU_D; end
      C_CBZ, C_CBNZ: begin s.reg2loc = 1'b1; s.seu = SEU_CB; s.alu_op = ALU_PASSB; end
      C_B:    s.seu = SEU_B;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcycle_cu_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and
// the control strobes, selects and trap flags returned to it.
interface mcycle_cu_if #(
  parameter int OPW    = 11,
  parameter int ALUOPW = 3
);
  logic [OPW-1:0]    opcode;
  logic              zero;
  logic              mem_ready;
  logic              ir_wr, pc_wr, pc_src;
  logic              mem_rd, mem_wr;
  logic              reg2loc, alu_src, mem_to_reg, reg_wr;
  logic [1:0]        seu;
  logic [ALUOPW-1:0] alu_op;
  logic              illegal, timeout;
  logic [2:0]        state;

  modport master (
    output opcode, zero, mem_ready,
    input  ir_wr, pc_wr, pc_src, mem_rd, mem_wr, reg2loc, alu_src,
           mem_to_reg, reg_wr, seu, alu_op, illegal, timeout, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output ir_wr, pc_wr, pc_src, mem_rd, mem_wr, reg2loc, alu_src,
           mem_to_reg, reg_wr, seu, alu_op, illegal, timeout, state
  );
endinterface

// File: rtl/mcycle_decode.sv
// Purely combinational opcode classifier; longer patterns take priority
// over shorter ones (11-bit, then 10-bit, then 8-bit, then 6-bit).
module mcycle_decode
  import mcycle_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic [OPW-1:0] i_opcode,
  output class_e         o_class
);

  logic [10:0] w_op;
  assign w_op = i_opcode[OPW-1 -: 11];

  always_comb begin
    // NOTE: default first so every path assigns o_class and no latch is inferred.
    o_class = C_NONE;
    if      (w_op == OP_ADD)        o_class = C_ADD;
    else if (w_op == OP_SUB)        o_class = C_SUB;
    else if (w_op == OP_AND)        o_class = C_AND;
    else if (w_op == OP_ORR)        o_class = C_ORR;
    else if (w_op == OP_LDUR)       o_class = C_LDUR;
    else if (w_op == OP_STUR)       o_class = C_STUR;
    else if (w_op[10:1] == OP_ADDI) o_class = C_ADDI;
    else if (w_op[10:1] == OP_SUBI) o_class = C_SUBI;
    else if (w_op[10:1] == OP_ANDI) o_class = C_ANDI;
    else if (w_op[10:1] == OP_ORRI) o_class = C_ORRI;
    else if (w_op[10:3] == OP_CBZ)  o_class = C_CBZ;
    else if (w_op[10:3] == OP_CBNZ) o_class = C_CBNZ;
    else if (w_op[10:5] == OP_B)    o_class = C_B;
  end

endmodule

// File: rtl/mcycle_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded
// memory-wait counter and sticky illegal/timeout traps that park the FSM in HALT.
module mcycle_cu
  import mcycle_pkg::*;
#(
  parameter int OPW      = 11,
  parameter int ALUOPW   = 3,
  parameter int WAIT_MAX = 15
) (
  input logic         clk,
  input logic         rst,
  mcycle_cu_if.slave  bus
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_e         r_state;
  class_e         r_class;
  sel_t           r_sel;
  logic [WCW-1:0] r_wait;
  logic           r_illegal, r_timeout;

  class_e         w_dec_class;
  logic [WCW-1:0] w_wait_inc;
  logic           w_wait_hit;
  logic           w_ir_wr, w_pc_wr, w_pc_src, w_mem_rd, w_mem_wr, w_reg_wr;

  mcycle_decode #(.OPW(OPW)) u_decode (
    .i_opcode (bus.opcode),
    .o_class  (w_dec_class)
  );

  assign w_wait_inc = r_wait + WCW'(1);
  assign w_wait_hit = (w_wait_inc == WCW'(WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_class   <= C_NONE;
      r_sel     <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_state <= S_DECODE;
          end else begin
            r_wait <= w_wait_inc;
            if (w_wait_hit) begin
              r_timeout <= 1'b1;
              r_state   <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          r_class <= w_dec_class;
          if (w_dec_class == C_NONE) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_sel   <= class_sels(w_dec_class);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch(r_class)) begin
            r_sel   <= '0;
            r_wait  <= '0;
            r_state <= S_FETCH;
          end else if (is_mem(r_class)) begin
            r_wait  <= '0;
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          // A completing handshake beats an expiring wait counter in the same cycle.
          if (bus.mem_ready) begin
            if (r_class == C_LDUR) begin
              r_state <= S_WB;
            end else begin
              r_sel   <= '0;
              r_wait  <= '0;
              r_state <= S_FETCH;
            end
          end else begin
            r_wait <= w_wait_inc;
            if (w_wait_hit) begin
              r_timeout <= 1'b1;
              r_sel     <= '0;
              r_state   <= S_HALT;
            end
          end
        end
        S_WB: begin
          r_sel   <= '0;
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_HALT: ;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Strobes follow the current state and same-cycle handshake inputs; all 0 in reset.
  always_comb begin
    w_ir_wr  = 1'b0;
    w_pc_wr  = 1'b0;
    w_pc_src = 1'b0;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_reg_wr = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_rd = 1'b1;
          w_ir_wr  = bus.mem_ready;
        end
        S_EXEC: begin
          if (is_branch(r_class)) begin
            w_pc_wr  = 1'b1;
            w_pc_src = (r_class == C_B) ||
                       ((r_class == C_CBZ)  &&  bus.zero) ||
                       ((r_class == C_CBNZ) && !bus.zero);
          end
        end
        S_MEM: begin
          w_mem_rd = (r_class == C_LDUR);
          w_mem_wr = (r_class == C_STUR);
          w_pc_wr  = (r_class == C_STUR) && bus.mem_ready;
        end
        S_WB: begin
          w_reg_wr = 1'b1;
          w_pc_wr  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ir_wr      = w_ir_wr;
  assign bus.pc_wr      = w_pc_wr;
  assign bus.pc_src     = w_pc_src;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.reg_wr     = w_reg_wr;
  assign bus.reg2loc    = r_sel.reg2loc;
  assign bus.alu_src    = r_sel.alu_src;
  assign bus.mem_to_reg = r_sel.mem_to_reg;
  assign bus.seu        = r_sel.seu;
  assign bus.alu_op     = ALUOPW'(r_sel.alu_op);
  assign bus.illegal    = r_illegal;
  assign bus.timeout    = r_timeout;
  assign bus.state      = r_state;

endmodule

// File: doc/mcycle_cu.md
MCYCLE_CU -- requirements
Module: mcycle_cu

Interface
REQ-001 Parameter OPW, default 11, opcode width; decode uses opcode[OPW-1 -: 11], and OPW below 11 is illegal.
REQ-002 Parameter ALUOPW, default 3, ALU operation code width.
REQ-003 Parameter WAIT_MAX, default 15, maximum cycles to wait for mem_ready before trapping.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 opcode  in  OPW  instruction opcode field from the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completion handshake.
REQ-009 ir_wr, pc_wr, pc_src  out  1 each  instruction-register load, PC load, branch-target select.
REQ-010 mem_rd, mem_wr  out  1 each  memory read / write request.
REQ-011 reg2loc, alu_src, mem_to_reg, reg_wr  out  1 each  datapath selects and register-file write enable.
REQ-012 seu  out  2  sign-extend mode: 00 = I-type, 01 = D-type, 10 = B, 11 = CB.
REQ-013 alu_op  out  ALUOPW  ALU operation: 0 = ADD, 1 = SUB, 2 = AND, 3 = ORR, 4 = PASS-B.
REQ-014 illegal, timeout  out  1 each  sticky trap flags.
REQ-015 state  out  3  current FSM state encoding, for debug.

Function
REQ-016 The FSM SHALL have six states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-017 FETCH: mem_rd=1 while waiting; on mem_ready=1, pulse ir_wr=1 for that cycle and go to DECODE.
REQ-018 DECODE: classify opcode into a registered class; match priority is 11-bit (ADD, SUB, AND, ORR, LDUR, STUR), then 10-bit (ADDI, SUBI, ANDI, ORRI), then 8-bit (CBZ, CBNZ), then 6-bit (B).
REQ-019 Opcode encodings: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, ADDI 1001000100x, SUBI 1101000100x, ANDI 1001001000x, ORRI 1011001000x, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx.
REQ-020 An unmatched opcode in DECODE SHALL set illegal=1 and go to HALT.
REQ-021 EXEC, for R-type and I-type: go to WB; for LDUR or STUR: go to MEM.
REQ-022 EXEC, for branches: assert pc_wr=1 for one cycle and go to FETCH.
REQ-023 Branch pc_src: B gives 1; CBZ gives zero; CBNZ gives !zero; pc_src is combinational on zero in EXEC only.
REQ-024 MEM: hold mem_rd=1 (LDUR) or mem_wr=1 (STUR) until mem_ready=1.
REQ-025 MEM exit: LDUR goes to WB; STUR asserts pc_wr=1 and goes to FETCH.
REQ-026 WB: assert reg_wr=1 and pc_wr=1 (pc_src=0) for exactly one cycle; mem_to_reg=1 for LDUR, else 0; go to FETCH.
REQ-027 Datapath selects SHALL be held for the whole instruction from EXEC onward.
REQ-028 Selects: reg2loc=1 for STUR, CBZ, CBNZ; alu_src=1 for I-type, LDUR, STUR; alu_op=4 for CB; otherwise as in REQ-012/REQ-013.
REQ-029 Any output not meaningful for the class SHALL be driven 0, never X.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-031 When the wait counter reaches WAIT_MAX, the FSM SHALL set timeout=1 and go to HALT; mem_ready=1 in that same cycle wins.
REQ-032 HALT SHALL be absorbing, with all strobes 0 and flags held, until rst.
REQ-033 Instruction latency without wait states: R/I = 4 cycles, LDUR = 5, STUR = 4, branches = 3.

Reset
REQ-034 On rst=1, immediately and asynchronously: state=FETCH, class register, wait counter, illegal and timeout all 0.
REQ-035 While rst=1 all outputs SHALL be 0; a mid-instruction rst SHALL abandon the instruction with no pc_wr or reg_wr.

Structure
REQ-036 Package mcycle_pkg SHALL hold the state enum, instruction-class enum, opcode constants and alu_op constants.
REQ-037 Sub-module mcycle_decode SHALL be the purely combinational opcode-to-class decoder; the FSM stays in mcycle_cu.

Verification
REQ-038 ADD, mem_ready=1 always -> states 0,1,2,4; reg_wr=1 and pc_wr=1 at cycle 4; alu_op=0.
REQ-039 LDUR with mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles, then WB with mem_to_reg=1.
REQ-040 CBZ with zero=1 -> pc_src=1 and pc_wr=1 in EXEC; repeat with zero=0 -> pc_src=0.
REQ-041 opcode 00000000000 -> illegal=1, state=5, all strobes 0 until rst.
REQ-042 mem_ready held 0 in FETCH -> timeout=1 after 15 cycles; rst clears it and returns state to 0.
REQ-043 rst asserted in MEM during STUR -> no mem_wr or pc_wr after reset; the next instruction fetches cleanly.
